// File: rtl/bootrom_arbiter.sv
// bootrom_arbiter: shares a single-port 8KB boot ROM between the CPU bus
// (port 0) and a read-only scanner (port 1) with round-robin arbitration.
// Each access walks IDLE -> WAIT -> DONE, so ready follows valid by 2 cycles.
// Optional feature macro: BOOTROM_LOCK_EN (sticky lock that blocks port 0).
module bootrom_arbiter #(
   parameter logic [31:0] ROM_BASE   = 32'h0004_0000,
   parameter int          ROM_ADDR_W = 13
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  p0_valid,
   input  logic [31:0]           p0_addr,
   input  logic [3:0]            p0_wstrb,
   output logic                  p0_ready,
   output logic [31:0]           p0_rdata,
   input  logic                  p1_valid,
   input  logic [31:0]           p1_addr,
   output logic                  p1_ready,
   output logic [31:0]           p1_rdata,
   output logic                  rom_enable,
   output logic [ROM_ADDR_W-1:0] rom_addr,
   input  logic [31:0]           rom_rdata,
   output logic                  fault,
   input  logic                  lock
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state, w_next;
   logic        r_last;      // last granted port, 1 at reset so port 0 wins first tie
   logic        r_port;      // port owning the transaction in flight
   logic        r_legal;     // in flight access is a permitted ROM read
   logic        r_fault;
   logic [31:0] r_rdata0, r_rdata1;

   logic        w_sel1, w_grant, w_inwin, w_wr, w_blk, w_legal;
   logic [31:0] w_addr;

   // Port 1 wins when alone, or on a tie when port 0 was served last.
   assign w_sel1  = p1_valid & (~p0_valid | ~r_last);
   assign w_grant = (r_state == S_IDLE) & (p0_valid | p1_valid);
   assign w_addr  = w_sel1 ? p1_addr : p0_addr;
   assign w_inwin = (w_addr[31:ROM_ADDR_W] == ROM_BASE[31:ROM_ADDR_W]);
   assign w_wr    = ~w_sel1 & (|p0_wstrb);

`ifdef BOOTROM_LOCK_EN
   logic r_locked;

   // Sticky boot-complete lock; only reset reopens the ROM to port 0.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)   r_locked <= 1'b0;
      else if (lock) r_locked <= 1'b1;
   end

   assign w_blk = ~w_sel1 & r_locked;
`else
   logic w_unused_lock;
   assign w_unused_lock = lock;
   assign w_blk         = 1'b0;
`endif

   assign w_legal = w_inwin & ~w_wr & ~w_blk;

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next state and the combinational ROM strobe issued in the grant cycle.
   always_comb begin
      w_next     = r_state;
      rom_enable = 1'b0;
      rom_addr   = '0;
      case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               w_next = S_WAIT;
               if (w_legal) begin
                  rom_enable = 1'b1;
                  rom_addr   = w_addr[ROM_ADDR_W-1:0];
               end
            end
         end
         S_WAIT:  w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Latch the grant decision for the WAIT/DONE cycles.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_last  <= 1'b1;
         r_port  <= 1'b0;
         r_legal <= 1'b0;
      end else if (w_grant) begin
         r_last  <= w_sel1;
         r_port  <= w_sel1;
         r_legal <= w_legal;
      end
   end

   // Capture ROM data (or zero for illegal accesses) and flag faults in WAIT.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rdata0 <= '0;
         r_rdata1 <= '0;
         r_fault  <= 1'b0;
      end else if (r_state == S_WAIT) begin
         if (r_port) r_rdata1 <= r_legal ? rom_rdata : 32'h0;
         else        r_rdata0 <= r_legal ? rom_rdata : 32'h0;
         if (!r_legal) r_fault <= 1'b1;
      end
   end

   assign p0_ready = (r_state == S_DONE) & ~r_port;
   assign p1_ready = (r_state == S_DONE) &  r_port;
   assign p0_rdata = r_rdata0;
   assign p1_rdata = r_rdata1;
   assign fault    = r_fault;

endmodule

// File: tb/tb_bootrom_arbiter.sv
// Self-checking bench for bootrom_arbiter: directed scenarios plus a
// randomized run against a transaction-level model of arbitration and ROM.
module tb_bootrom_arbiter;

   localparam logic [31:0] BASE = 32'h0004_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        p0_valid, p1_valid;
   logic [31:0] p0_addr, p1_addr;
   logic [3:0]  p0_wstrb;
   logic        p0_ready, p1_ready;
   logic [31:0] p0_rdata, p1_rdata;
   logic        rom_enable;
   logic [12:0] rom_addr;
   logic [31:0] rom_rdata = '0;
   logic        fault;
   logic        lock;

   logic [31:0] mem [0:2047];
   int          total = 0;
   int          bad   = 0;

   // model state
   logic        m_last, m_fault;
   logic [31:0] m_rd0, m_rd1;

   bootrom_arbiter #(.ROM_BASE(BASE), .ROM_ADDR_W(13)) dut (
      .clk(clk), .resetn(resetn),
      .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wstrb(p0_wstrb),
      .p0_ready(p0_ready), .p0_rdata(p0_rdata),
      .p1_valid(p1_valid), .p1_addr(p1_addr),
      .p1_ready(p1_ready), .p1_rdata(p1_rdata),
      .rom_enable(rom_enable), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
      .fault(fault), .lock(lock)
   );

   always #5 clk = ~clk;

   // Registered single-port ROM model.
   always @(posedge clk) if (rom_enable) rom_rdata <= mem[rom_addr[12:2]];

   task automatic do_reset();
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      m_last = 1'b1; m_fault = 1'b0; m_rd0 = '0; m_rd1 = '0;
   endtask

   task automatic idle_inputs();
      p0_valid = 1'b0; p1_valid = 1'b0; p0_wstrb = 4'h0;
      p0_addr = '0; p1_addr = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b%b want 00", p0_ready, p1_ready); end
      total++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", p0_rdata, p1_rdata); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", fault); end
      total++; if (rom_enable !== 1'b0 || rom_addr !== 13'h0) begin bad++; $display("FAIL reset_rom: got en=%b addr=%h want 0/0", rom_enable, rom_addr); end
      resetn = 1'b1;
      m_last = 1'b1; m_fault = 1'b0; m_rd0 = '0; m_rd1 = '0;
   endtask

   task automatic test_p0_read();
      p0_valid = 1'b1; p0_addr = BASE; p0_wstrb = 4'h0;
      #1;
      total++; if (rom_enable !== 1'b1 || rom_addr !== 13'h0) begin bad++; $display("FAIL p0rd_rom: got en=%b addr=%h want 1/0", rom_enable, rom_addr); end
      @(negedge clk);
      total++; if (p0_ready !== 1'b0) begin bad++; $display("FAIL p0rd_early: got ready=%b want 0", p0_ready); end
      @(negedge clk);
      total++; if (p0_ready !== 1'b1 || p0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL p0rd_data: got ready=%b data=%h want 1/deadbeef", p0_ready, p0_rdata); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL p0rd_fault: got %b want 0", fault); end
      p0_valid = 1'b0;
      @(negedge clk);
      total++; if (p0_ready !== 1'b0) begin bad++; $display("FAIL p0rd_pulse: got ready=%b want 0", p0_ready); end
      m_last = 1'b0; m_rd0 = 32'hDEADBEEF;
   endtask

   task automatic test_back_to_back();
      logic e0, e1;
      resetn = 1'b0;
      p0_valid = 1'b1; p0_addr = BASE + 32'h4;    p0_wstrb = 4'h0;
      p1_valid = 1'b1; p1_addr = BASE + 32'h1FFC;
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         e0 = (k % 6 == 2);
         e1 = (k % 6 == 5);
         total++; if (p0_ready !== e0 || p1_ready !== e1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b%b want %b%b", k, p0_ready, p1_ready, e0, e1); end
         if (e0) begin total++; if (p0_rdata !== mem[1]) begin bad++; $display("FAIL b2b_p0data[%0d]: got %h want %h", k, p0_rdata, mem[1]); end end
         if (e1) begin total++; if (p1_rdata !== mem[2047]) begin bad++; $display("FAIL b2b_p1data[%0d]: got %h want %h", k, p1_rdata, mem[2047]); end end
      end
      idle_inputs();
      @(negedge clk);
      m_last = 1'b1; m_fault = 1'b0; m_rd0 = mem[1]; m_rd1 = mem[2047];
   endtask

   task automatic test_out_of_window();
      p0_valid = 1'b1; p0_addr = 32'h0004_2000; p0_wstrb = 4'h0;
      #1;
      total++; if (rom_enable !== 1'b0) begin bad++; $display("FAIL oow_rom: got en=%b want 0", rom_enable); end
      repeat (2) @(negedge clk);
      total++; if (p0_ready !== 1'b1 || p0_rdata !== 32'h0) begin bad++; $display("FAIL oow_data: got ready=%b data=%h want 1/0", p0_ready, p0_rdata); end
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL oow_fault: got %b want 1", fault); end
      p0_valid = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (fault !== 1'b1) begin bad++; $display("FAIL oow_sticky: got %b want 1", fault); end
      m_last = 1'b0; m_fault = 1'b1; m_rd0 = '0;
   endtask

   task automatic test_write();
      logic any_en;
      do_reset();
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL wr_prefault: got %b want 0", fault); end
      p0_valid = 1'b1; p0_addr = BASE + 32'h10; p0_wstrb = 4'hF;
      #1; any_en = rom_enable;
      @(negedge clk); any_en |= rom_enable;
      @(negedge clk); any_en |= rom_enable;
      total++; if (any_en !== 1'b0) begin bad++; $display("FAIL wr_rom: got en=%b want 0", any_en); end
      total++; if (p0_ready !== 1'b1 || p0_rdata !== 32'h0 || fault !== 1'b1) begin bad++; $display("FAIL wr_done: got ready=%b data=%h fault=%b want 1/0/1", p0_ready, p0_rdata, fault); end
      idle_inputs();
      @(negedge clk);
      m_last = 1'b0; m_fault = 1'b1; m_rd0 = '0;
   endtask

   task automatic test_reset_mid();
      // legal read first so the registers hold non-reset values
      p0_valid = 1'b1; p0_addr = BASE + 32'h8;
      repeat (2) @(negedge clk);
      total++; if (p0_ready !== 1'b1 || p0_rdata !== mem[2]) begin bad++; $display("FAIL rstmid_pre: got ready=%b data=%h want 1/%h", p0_ready, p0_rdata, mem[2]); end
      p0_valid = 1'b0;
      @(negedge clk);
      p0_valid = 1'b1; p0_addr = BASE + 32'hC;
      @(negedge clk);
      resetn = 1'b0;
      #1;
      total++; if (p0_rdata !== 32'h0 || fault !== 1'b0 || p0_ready !== 1'b0) begin bad++; $display("FAIL rstmid_async: got data=%h fault=%b ready=%b want 0/0/0", p0_rdata, fault, p0_ready); end
      p0_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         total++; if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin bad++; $display("FAIL rstmid_noready: got %b%b want 00", p0_ready, p1_ready); end
      end
      resetn = 1'b1;
      m_last = 1'b1; m_fault = 1'b0; m_rd0 = '0; m_rd1 = '0;
      p0_valid = 1'b1; p0_addr = BASE + 32'h8;
      repeat (2) @(negedge clk);
      total++; if (p0_ready !== 1'b1 || p0_rdata !== mem[2]) begin bad++; $display("FAIL rstmid_after: got ready=%b data=%h want 1/%h", p0_ready, p0_rdata, mem[2]); end
      p0_valid = 1'b0;
      @(negedge clk);
      m_last = 1'b0; m_rd0 = mem[2];
   endtask

   function automatic logic [31:0] gen_addr();
      case ($urandom_range(0, 7))
         0:       return $urandom;
         1:       return BASE + 32'h2000;
         2:       return BASE - 32'h4;
         default: return BASE + $urandom_range(0, 8191);
      endcase
   endfunction

   task automatic test_random();
      logic        v0, v1, win, legal;
      logic [31:0] a0, a1, a, exp_d;
      logic [3:0]  ws;
      do_reset();
      for (int r = 0; r < 60; r++) begin
         v0 = ($urandom_range(0, 2) != 0);
         v1 = ($urandom_range(0, 2) != 0);
         a0 = gen_addr(); a1 = gen_addr();
         ws = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         p0_valid = v0; p0_addr = a0; p0_wstrb = ws;
         p1_valid = v1; p1_addr = a1;
         #1;
         if (!v0 && !v1) begin
            total++; if (rom_enable !== 1'b0 || rom_addr !== 13'h0) begin bad++; $display("FAIL rnd_idle[%0d]: got en=%b addr=%h want 0/0", r, rom_enable, rom_addr); end
            @(negedge clk);
         end else begin
            // round robin: lone requester wins; on a tie, the one not served last
            win   = (v0 && v1) ? ~m_last : v1;
            a     = win ? a1 : a0;
            legal = (a >= BASE) && (a < BASE + 32'h2000) && (win || ws == 4'h0);
            exp_d = legal ? mem[(a - BASE) >> 2] : 32'h0;
            total++; if (rom_enable !== legal) begin bad++; $display("FAIL rnd_en[%0d]: got %b want %b", r, rom_enable, legal); end
            if (legal) begin total++; if (rom_addr !== a[12:0]) begin bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", r, rom_addr, a[12:0]); end end
            @(negedge clk);
            total++; if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin bad++; $display("FAIL rnd_early[%0d]: got %b%b want 00", r, p0_ready, p1_ready); end
            @(negedge clk);
            m_last  = win;
            m_fault = m_fault | ~legal;
            if (win) m_rd1 = exp_d; else m_rd0 = exp_d;
            total++; if (p0_ready !== ~win || p1_ready !== win) begin bad++; $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", r, p0_ready, p1_ready, ~win, win); end
            total++; if (p0_rdata !== m_rd0 || p1_rdata !== m_rd1) begin bad++; $display("FAIL rnd_data[%0d]: got %h/%h want %h/%h", r, p0_rdata, p1_rdata, m_rd0, m_rd1); end
            total++; if (fault !== m_fault) begin bad++; $display("FAIL rnd_fault[%0d]: got %b want %b", r, fault, m_fault); end
            idle_inputs();
            @(negedge clk);
         end
      end
   endtask

`ifdef BOOTROM_LOCK_EN
   task automatic test_lock();
      do_reset();
      lock = 1'b1;
      @(negedge clk);
      lock = 1'b0;
      @(negedge clk);
      p0_valid = 1'b1; p0_addr = BASE;
      #1;
      total++; if (rom_enable !== 1'b0) begin bad++; $display("FAIL lock_p0en: got %b want 0", rom_enable); end
      repeat (2) @(negedge clk);
      total++; if (p0_ready !== 1'b1 || p0_rdata !== 32'h0 || fault !== 1'b1) begin bad++; $display("FAIL lock_p0: got ready=%b data=%h fault=%b want 1/0/1", p0_ready, p0_rdata, fault); end
      idle_inputs();
      @(negedge clk);
      p1_valid = 1'b1; p1_addr = BASE;
      #1;
      total++; if (rom_enable !== 1'b1) begin bad++; $display("FAIL lock_p1en: got %b want 1", rom_enable); end
      repeat (2) @(negedge clk);
      total++; if (p1_ready !== 1'b1 || p1_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lock_p1: got ready=%b data=%h want 1/deadbeef", p1_ready, p1_rdata); end
      idle_inputs();
      @(negedge clk);
   endtask
`endif

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = $urandom;
      mem[0] = 32'hDEADBEEF;
      lock = 1'b0;
      resetn = 1'b0;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_p0_read();
      test_back_to_back();
      test_out_of_window();
      test_write();
      test_reset_mid();
      test_random();
`ifdef BOOTROM_LOCK_EN
      test_lock();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
